branch_resolve_unit: RTL and testbench

- EX/MEM-stage resolver for conditional branches predicted in ID by the gshare jump/branch unit.
- Evaluates the RV32I branch condition and compares the result with the ID-stage prediction.
- Registers a one-cycle MEM-stage update (branch_resolved, actual_taken, pht_indexMEM) back to the predictor.
- Issues a mispredict flush with the corrected fetch PC.

---
 rtl/branch_resolve_unit_pkg.sv | 18 +
 rtl/branch_resolve_unit_cmp.sv | 34 +++
 rtl/branch_resolve_unit.sv | 109 ++++++++++
 tb/tb_branch_resolve_unit.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// Shared encodings for the branch resolve unit: RV32I branch funct3 codes,
// resolver FSM states and the default fall-through increment.
package branch_resolve_unit_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REPORT = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  localparam int BRANCH_SIZE_BYTES = 4;

endpackage

// File: rtl/branch_resolve_unit_cmp.sv
// Combinational RV32I branch condition evaluator: funct3/rs1/rs2 -> taken, legal.
module branch_cmp
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            taken,
  output logic            legal
);

  logic signed [XLEN-1:0] rs1_s;
  logic signed [XLEN-1:0] rs2_s;

  assign rs1_s = rs1;
  assign rs2_s = rs2;

  always_comb begin
    taken = 1'b0;
    legal = 1'b1;
    case (funct3)
      F3_BEQ:  taken = (rs1 == rs2);
      F3_BNE:  taken = (rs1 != rs2);
      F3_BLT:  taken = (rs1_s <  rs2_s);
      F3_BGE:  taken = (rs1_s >= rs2_s);
      F3_BLTU: taken = (rs1 <  rs2);
      F3_BGEU: taken = (rs1 >= rs2);
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX/MEM branch resolver: checks the ID-stage gshare prediction, strobes a
// one-cycle PHT update and mispredict redirect. Stats counters under BRANCH_STATS_EN.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int PHT_IDX_W   = 3,
  parameter int BRANCH_SIZE = BRANCH_SIZE_BYTES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 flush_ex,
  input  logic                 branch_ex,
  input  logic [2:0]           funct3_ex,
  input  logic [XLEN-1:0]      rs1_ex,
  input  logic [XLEN-1:0]      rs2_ex,
  input  logic [XLEN-1:0]      pc_ex,
  input  logic [XLEN-1:0]      imm_ex,
  input  logic                 pred_taken_ex,
  input  logic [PHT_IDX_W-1:0] pht_index_ex,
  output logic                 branch_resolved,
  output logic                 actual_taken,
  output logic [PHT_IDX_W-1:0] pht_indexMEM,
  output logic                 mispredict,
  output logic [XLEN-1:0]      redirect_pc,
  output logic [31:0]          branch_count,
  output logic [31:0]          mispredict_count
);

  logic                 taken_p0;
  logic                 legal_p0;
  logic                 capture_p0;
  logic [XLEN-1:0]      target_p0;

  logic [1:0]           state_p1;
  logic [1:0]           state_next;
  logic                 taken_p1;
  logic                 mis_p1;
  logic [PHT_IDX_W-1:0] idx_p1;
  logic [XLEN-1:0]      target_p1;

  branch_cmp #(.XLEN(XLEN)) u_cmp (
    .funct3 (funct3_ex),
    .rs1    (rs1_ex),
    .rs2    (rs2_ex),
    .taken  (taken_p0),
    .legal  (legal_p0)
  );

  assign capture_p0 = branch_ex && legal_p0 && !flush_ex && !stall;
  assign target_p0  = taken_p0 ? (pc_ex + imm_ex) : (pc_ex + XLEN'(BRANCH_SIZE));

  // A held entry never re-enters REPORT on its own, so each branch strobes once.
  always_comb begin
    state_next = ST_IDLE;
    if (capture_p0)
      state_next = ST_REPORT;
    else if (stall && (state_p1 != ST_IDLE))
      state_next = ST_HOLD;
  end

  // EX -> MEM register boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_p1  <= ST_IDLE;
      taken_p1  <= 1'b0;
      mis_p1    <= 1'b0;
      idx_p1    <= '0;
      target_p1 <= '0;
    end else begin
      state_p1 <= state_next;
      if (capture_p0) begin
        taken_p1  <= taken_p0;
        mis_p1    <= (taken_p0 != pred_taken_ex);
        idx_p1    <= pht_index_ex;
        target_p1 <= target_p0;
      end
    end
  end

  assign branch_resolved = (state_p1 == ST_REPORT);
  assign mispredict      = branch_resolved && mis_p1;
  assign actual_taken    = taken_p1;
  assign pht_indexMEM    = idx_p1;
  assign redirect_pc     = target_p1;

`ifdef BRANCH_STATS_EN
  logic [31:0] bcnt_p2;
  logic [31:0] mcnt_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt_p2 <= '0;
      mcnt_p2 <= '0;
    end else begin
      if (branch_resolved && (bcnt_p2 != 32'hFFFF_FFFF)) bcnt_p2 <= bcnt_p2 + 32'd1;
      if (mispredict && (mcnt_p2 != 32'hFFFF_FFFF))      mcnt_p2 <= mcnt_p2 + 32'd1;
    end
  end

  assign branch_count     = bcnt_p2;
  assign mispredict_count = mcnt_p2;
`else
  assign branch_count     = 32'd0;
  assign mispredict_count = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus random
// traffic against a transaction-level reference model. Honours BRANCH_STATS_EN.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush_ex, branch_ex, pred_taken_ex;
  logic [2:0]  funct3_ex, pht_index_ex;
  logic [31:0] rs1_ex, rs2_ex, pc_ex, imm_ex;
  logic        branch_resolved, actual_taken, mispredict;
  logic [2:0]  pht_indexMEM;
  logic [31:0] redirect_pc, branch_count, mispredict_count;

  int checks = 0;
  int passed = 0;

  // reference model: what the outputs must show after the most recent edge
  logic        exp_res, exp_mis, exp_taken;
  logic [2:0]  exp_idx;
  logic [31:0] exp_pc, exp_bc, exp_mc, exp_bco, exp_mco;

  branch_resolve_unit #(.XLEN(32), .PHT_IDX_W(3), .BRANCH_SIZE(4)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush_ex(flush_ex), .branch_ex(branch_ex),
    .funct3_ex(funct3_ex), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .pc_ex(pc_ex), .imm_ex(imm_ex),
    .pred_taken_ex(pred_taken_ex), .pht_index_ex(pht_index_ex),
    .branch_resolved(branch_resolved), .actual_taken(actual_taken), .pht_indexMEM(pht_indexMEM),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .branch_count(branch_count), .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int signed sa, sb;
    sa = a; sb = b;
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return sa < sb;
      3'd5: return sa >= sb;
      3'd6: return a < b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_clear();
    exp_res = 0; exp_mis = 0; exp_taken = 0; exp_idx = 0; exp_pc = 0;
    exp_bc = 0; exp_mc = 0; exp_bco = 0; exp_mco = 0;
  endtask

  // Drive one cycle of inputs, clock, and advance the model to the post-edge view.
  task automatic cycle(input logic br, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [31:0] imm, input logic pred,
                       input logic [2:0] idx, input logic st, input logic fl);
    logic cap, tk;
    branch_ex = br; funct3_ex = f3; rs1_ex = a; rs2_ex = b; pc_ex = pc; imm_ex = imm;
    pred_taken_ex = pred; pht_index_ex = idx; stall = st; flush_ex = fl;
    cap = br && (f3 != 3'd2) && (f3 != 3'd3) && !fl && !st;
    tk  = ref_taken(f3, a, b);
    @(posedge clk); #1;
    if (exp_res && exp_bc != 32'hFFFF_FFFF) exp_bc++;
    if (exp_mis && exp_mc != 32'hFFFF_FFFF) exp_mc++;
    exp_res = cap;
    exp_mis = cap && (tk != pred);
    if (cap) begin
      exp_taken = tk; exp_idx = idx; exp_pc = tk ? pc + imm : pc + 32'd4;
    end
`ifdef BRANCH_STATS_EN
    exp_bco = exp_bc; exp_mco = exp_mc;
`else
    exp_bco = 0; exp_mco = 0;
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    branch_ex = 0; funct3_ex = 0; rs1_ex = 0; rs2_ex = 0; pc_ex = 0; imm_ex = 0;
    pred_taken_ex = 0; pht_index_ex = 0; stall = 0; flush_ex = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #3 rst = 0;
    model_clear();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({branch_resolved, mispredict, actual_taken} !== 3'b000) $display("FAIL reset_strobes got %b exp 000", {branch_resolved, mispredict, actual_taken}); else passed++;
    checks++; if (pht_indexMEM !== 3'd0 || redirect_pc !== 32'd0) $display("FAIL reset_data got idx=%0d pc=%h exp 0", pht_indexMEM, redirect_pc); else passed++;
    checks++; if (branch_count !== 0 || mispredict_count !== 0) $display("FAIL reset_counters got %0d/%0d exp 0/0", branch_count, mispredict_count); else passed++;
  endtask

  task automatic test_directed();
    cycle(1, 3'd0, 5, 5, 32'h100, 32'h20, 0, 3'd1, 0, 0);
    checks++; if ({branch_resolved, actual_taken, mispredict} !== 3'b111) $display("FAIL beq_strobe got %b exp 111", {branch_resolved, actual_taken, mispredict}); else passed++;
    checks++; if (redirect_pc !== 32'h120) $display("FAIL beq_redirect got %h exp 00000120", redirect_pc); else passed++;
    cycle(1, 3'd4, 32'hFFFF_FFFF, 1, 32'h200, 32'h40, 1, 3'd2, 0, 0);
    checks++; if ({branch_resolved, actual_taken, mispredict} !== 3'b110) $display("FAIL blt_signed got %b exp 110", {branch_resolved, actual_taken, mispredict}); else passed++;
    cycle(1, 3'd6, 32'hFFFF_FFFF, 1, 32'h200, 32'h40, 1, 3'd3, 0, 0);
    checks++; if ({branch_resolved, actual_taken, mispredict} !== 3'b101) $display("FAIL bltu_unsigned got %b exp 101", {branch_resolved, actual_taken, mispredict}); else passed++;
    checks++; if (redirect_pc !== 32'h204) $display("FAIL bltu_redirect got %h exp 00000204", redirect_pc); else passed++;
    idle(1);
  endtask

  task automatic test_stall();
    int pulses = 0;
    cycle(1, 3'd1, 3, 4, 32'h300, 32'h10, 1, 3'd6, 0, 0);
    pulses += branch_resolved;
    checks++; if (mispredict !== 1'b0 || actual_taken !== 1'b1) $display("FAIL stall_pred got mis=%b tk=%b exp 0/1", mispredict, actual_taken); else passed++;
    for (int i = 0; i < 3; i++) begin
      cycle(1, 3'd0, 7, 7, 32'h400, 32'h8, 0, 3'd1, 1, 0);
      pulses += branch_resolved;
      checks++; if (pht_indexMEM !== 3'd6) $display("FAIL stall_idx_hold got %0d exp 6", pht_indexMEM); else passed++;
    end
    idle(2);
    pulses += branch_resolved;
    checks++; if (pulses != 1) $display("FAIL stall_single_pulse got %0d exp 1", pulses); else passed++;
  endtask

  task automatic test_back_to_back();
    cycle(1, 3'd0, 1, 1, 32'h500, 32'h4, 1, 3'b010, 0, 0);
    checks++; if (branch_resolved !== 1'b1 || pht_indexMEM !== 3'b010) $display("FAIL b2b_first got res=%b idx=%0d exp 1/2", branch_resolved, pht_indexMEM); else passed++;
    cycle(1, 3'd1, 1, 1, 32'h504, 32'h4, 0, 3'b101, 0, 0);
    checks++; if (branch_resolved !== 1'b1 || pht_indexMEM !== 3'b101) $display("FAIL b2b_second got res=%b idx=%0d exp 1/5", branch_resolved, pht_indexMEM); else passed++;
    idle(1);
    checks++; if (branch_resolved !== 1'b0) $display("FAIL b2b_drop got %b exp 0", branch_resolved); else passed++;
  endtask

  task automatic test_illegal_flush();
    cycle(1, 3'd2, 1, 1, 32'h600, 32'h4, 0, 3'd4, 0, 0);
    checks++; if (branch_resolved !== 1'b0 || mispredict !== 1'b0) $display("FAIL illegal_010 got %b%b exp 00", branch_resolved, mispredict); else passed++;
    cycle(1, 3'd3, 1, 2, 32'h600, 32'h4, 1, 3'd4, 0, 0);
    checks++; if (branch_resolved !== 1'b0) $display("FAIL illegal_011 got %b exp 0", branch_resolved); else passed++;
    cycle(1, 3'd0, 1, 1, 32'h700, 32'h4, 0, 3'd7, 0, 1);
    checks++; if (branch_resolved !== 1'b0 || mispredict !== 1'b0) $display("FAIL flush_nocap got %b%b exp 00", branch_resolved, mispredict); else passed++;
    // an entry already captured still reports while a younger one is flushed
    cycle(1, 3'd0, 1, 1, 32'h800, 32'h4, 0, 3'd3, 0, 0);
    branch_ex = 1; flush_ex = 1; #2;
    checks++; if (branch_resolved !== 1'b1 || mispredict !== 1'b1) $display("FAIL older_reports got %b%b exp 11", branch_resolved, mispredict); else passed++;
    rst = 1; #1;
    checks++; if ({branch_resolved, mispredict, actual_taken, pht_indexMEM, redirect_pc} !== 38'd0) $display("FAIL async_reset got res=%b mis=%b pc=%h exp 0", branch_resolved, mispredict, redirect_pc); else passed++;
    @(posedge clk); #3 rst = 0; flush_ex = 0; branch_ex = 0;
    model_clear();
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    for (int i = 0; i < 300; i++) begin
      a = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 3) - 2;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom_range(0, 3) - 2;
      cycle($urandom_range(0, 9) < 7, 3'($urandom), a, b, $urandom, $urandom, 1'($urandom), 3'($urandom),
            $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
      checks++; if (branch_resolved !== exp_res || mispredict !== exp_mis) $display("FAIL rand_strobe[%0d] got %b%b exp %b%b", i, branch_resolved, mispredict, exp_res, exp_mis); else passed++;
      checks++; if (actual_taken !== exp_taken || pht_indexMEM !== exp_idx) $display("FAIL rand_data[%0d] got %b/%0d exp %b/%0d", i, actual_taken, pht_indexMEM, exp_taken, exp_idx); else passed++;
      if (exp_mis) begin
        checks++; if (redirect_pc !== exp_pc) $display("FAIL rand_redirect[%0d] got %h exp %h", i, redirect_pc, exp_pc); else passed++;
      end
      checks++; if (branch_count !== exp_bco || mispredict_count !== exp_mco) $display("FAIL rand_counts[%0d] got %0d/%0d exp %0d/%0d", i, branch_count, mispredict_count, exp_bco, exp_mco); else passed++;
    end
  endtask

  task automatic test_stats();
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1, 3'd0, 9, 9, 32'h1000 + 32'(i * 4), 32'h40, i >= 3, 3'(i), 0, 0);
    idle(2);
`ifdef BRANCH_STATS_EN
    checks++; if (branch_count !== 32'd10 || mispredict_count !== 32'd3) $display("FAIL stats got %0d/%0d exp 10/3", branch_count, mispredict_count); else passed++;
`else
    checks++; if (branch_count !== 32'd0 || mispredict_count !== 32'd0) $display("FAIL stats_off got %0d/%0d exp 0/0", branch_count, mispredict_count); else passed++;
`endif
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_back_to_back();
    test_illegal_flush();
    test_random();
    test_stats();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
